// File: rtl/quad_scheduler.sv
// quad_scheduler: round-robin arbiter feeding shader quads to the serializer at a fixed issue cadence.
// Optional activity counters are compiled in with `define QUAD_SCHED_STATS_EN.
module quad_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ),
    parameter int SPACING = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ-1:0]    req_last,
    input  logic [NUM_REQ*32-1:0] req_r,
    input  logic [NUM_REQ*32-1:0] req_g,
    input  logic [NUM_REQ*32-1:0] req_b,
    input  logic                  out_ready,
`ifdef QUAD_SCHED_STATS_EN
    input  logic                  stat_clr,
    output logic [31:0]           stat_quads,
    output logic [31:0]           stat_stall,
`endif
    output logic                  valid_quad,
    output logic [31:0]           R_quad,
    output logic [31:0]           G_quad,
    output logic [31:0]           B_quad,
    output logic [IDX_W-1:0]      grant_id,
    output logic                  busy
);

    localparam int DATA_W = 32;
    localparam int CNT_W  = (SPACING > 1) ? $clog2(SPACING) : 1;

    logic [CNT_W-1:0]   space_cnt;
    logic               lock_held;
    logic [IDX_W-1:0]   lock_id;
    logic [IDX_W-1:0]   rr_ptr;

    logic               slot_free_p0;
    logic [NUM_REQ-1:0] eligible_p0;
    logic               found_p0;
    logic [IDX_W-1:0]   grant_p0;
    logic [IDX_W-1:0]   next_ptr_p0;
    logic               accept_p0;
    logic [DATA_W-1:0]  r_sel_p0;
    logic [DATA_W-1:0]  g_sel_p0;
    logic [DATA_W-1:0]  b_sel_p0;
    logic               last_sel_p0;

    // Stage p0: arbitration and operand select, all combinational on current state
    always_comb begin
        int               j;
        logic [IDX_W-1:0] cand;
        j            = 0;
        cand         = '0;
        slot_free_p0 = (space_cnt == '0) && out_ready && !rst;
        eligible_p0  = req_valid & (lock_held ? (NUM_REQ'(1) << lock_id) : {NUM_REQ{1'b1}});
        found_p0     = 1'b0;
        grant_p0     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            cand = IDX_W'(j);
            if (!found_p0 && eligible_p0[cand]) begin
                found_p0 = 1'b1;
                grant_p0 = cand;
            end
        end
        accept_p0 = slot_free_p0 && found_p0;
        req_ready = '0;
        if (accept_p0) req_ready[grant_p0] = 1'b1;
        next_ptr_p0 = (int'(grant_p0) == NUM_REQ - 1) ? '0 : grant_p0 + IDX_W'(1);
        r_sel_p0    = '0;
        g_sel_p0    = '0;
        b_sel_p0    = '0;
        last_sel_p0 = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_p0 == IDX_W'(i)) begin
                r_sel_p0    = req_r[i*DATA_W +: DATA_W];
                g_sel_p0    = req_g[i*DATA_W +: DATA_W];
                b_sel_p0    = req_b[i*DATA_W +: DATA_W];
                last_sel_p0 = req_last[i];
            end
        end
    end

    // Stage p1: issue registers and scheduler state
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_quad <= 1'b0;
            R_quad     <= '0;
            G_quad     <= '0;
            B_quad     <= '0;
            grant_id   <= '0;
            space_cnt  <= '0;
            lock_held  <= 1'b0;
            lock_id    <= '0;
            rr_ptr     <= '0;
        end else begin
            valid_quad <= accept_p0;
            if (space_cnt != '0) space_cnt <= space_cnt - CNT_W'(1);
            if (accept_p0) begin
                R_quad    <= r_sel_p0;
                G_quad    <= g_sel_p0;
                B_quad    <= b_sel_p0;
                grant_id  <= grant_p0;
                space_cnt <= CNT_W'(SPACING - 1);
                rr_ptr    <= next_ptr_p0;
                lock_held <= !last_sel_p0;
                lock_id   <= grant_p0;
            end
        end
    end

    assign busy = (space_cnt != '0) || lock_held;

`ifdef QUAD_SCHED_STATS_EN
    logic stall_p0;
    assign stall_p0 = (|req_valid) && !accept_p0;

    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            stat_quads <= '0;
            stat_stall <= '0;
        end else begin
            if (accept_p0) stat_quads <= stat_quads + 32'd1;
            if (stall_p0)  stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_quad_scheduler.sv
// Scoreboard bench for quad_scheduler: stimulus pushes expected issues, a monitor pops on valid_quad.
module tb_quad_scheduler;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [N-1:0]  req_last;
    logic [N*32-1:0] req_r, req_g, req_b;
    logic          out_ready;
    logic          valid_quad;
    logic [31:0]   R_quad, G_quad, B_quad;
    logic [1:0]    grant_id;
    logic          busy;
`ifdef QUAD_SCHED_STATS_EN
    logic          stat_clr;
    logic [31:0]   stat_quads, stat_stall;
`endif

    quad_scheduler #(.NUM_REQ(N), .SPACING(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_last(req_last),
        .req_r(req_r), .req_g(req_g), .req_b(req_b),
        .out_ready(out_ready),
`ifdef QUAD_SCHED_STATS_EN
        .stat_clr(stat_clr), .stat_quads(stat_quads), .stat_stall(stat_stall),
`endif
        .valid_quad(valid_quad), .R_quad(R_quad), .G_quad(G_quad), .B_quad(B_quad),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          lane;
        logic [31:0] r, g, b;
        int          cy;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] lr[N] = '{32'hAABBCCDD, 32'h11223344, 32'h55667788, 32'h99AABBCC};
    logic [31:0] lg[N] = '{32'h01020304, 32'h10203040, 32'hA0B0C0D0, 32'h0F0E0D0C};
    logic [31:0] lb[N] = '{32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678, 32'h87654321};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %h, required %h", nm, cyc, act, exp);
        end
    endtask

    task automatic push(input int lane);
        exp_t x;
        x.lane = lane;
        x.r    = lr[lane];
        x.g    = lg[lane];
        x.b    = lb[lane];
        x.cy   = cyc + 1;
        q.push_back(x);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_last  = '0;
        out_ready = 1'b1;
`ifdef QUAD_SCHED_STATS_EN
        stat_clr  = 1'b0;
`endif
        @(negedge clk);
        chk("ready_in_rst", 32'(req_ready), 32'h0);
        next();
        rst = 1'b0;
    endtask

    // Monitor: every issue strobe must match the oldest expected entry, including its cycle
    always @(negedge clk) begin
        if (valid_quad) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_issue @cycle %0d: valid_quad=1 grant=%0d, required no issue", cyc, grant_id);
            end else begin
                e = q.pop_front();
                chk("issue_cycle", 32'(cyc), 32'(e.cy));
                chk("grant_id", 32'(grant_id), 32'(e.lane));
                chk("R_quad", R_quad, e.r);
                chk("G_quad", G_quad, e.g);
                chk("B_quad", B_quad, e.b);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_last  = '0;
        out_ready = 1'b1;
`ifdef QUAD_SCHED_STATS_EN
        stat_clr  = 1'b0;
`endif
        for (int i = 0; i < N; i++) begin
            req_r[i*32 +: 32] = lr[i];
            req_g[i*32 +: 32] = lg[i];
            req_b[i*32 +: 32] = lb[i];
        end
        repeat (2) next();

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_valid_quad", 32'(valid_quad), 32'h0);
        chk("rst_R_quad", R_quad, 32'h0);
        chk("rst_grant_id", 32'(grant_id), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        next();

        // Single quad from lane 0, then spacing
        do_reset();
        req_valid = 4'b0001;
        req_last  = 4'b1111;
        @(negedge clk);
        chk("t1_ready", 32'(req_ready), 32'h1);
        chk("t1_busy0", 32'(busy), 32'h0);
        push(0);
        next();
        req_valid = '0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk("t1_busy", 32'(busy), 32'h1);
            if (c == 2) chk("t1_hold_R", R_quad, 32'hAABBCCDD);
            next();
        end
        @(negedge clk);
        chk("t1_busy_end", 32'(busy), 32'h0);
        next();

        // All lanes valid: round-robin 0,1,2,3,0 every 4 cycles
        do_reset();
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        for (int c = 0; c < 17; c++) begin
            @(negedge clk);
            if (c % 4 == 0) begin
                chk("rr_ready", 32'(req_ready), 32'(1 << ((c / 4) % 4)));
                push((c / 4) % 4);
            end else begin
                chk("rr_idle", 32'(req_ready), 32'h0);
            end
            next();
        end
        req_valid = '0;
        repeat (4) next();

        // Lane 1 locks for a 3-quad primitive while lane 2 waits
        do_reset();
        req_valid = 4'b0110;
        req_last  = 4'b0000;
        for (int c = 0; c <= 12; c++) begin
            req_last[1] = (c >= 8);
            if (c > 8) req_valid[1] = 1'b0;
            @(negedge clk);
            if (c == 0 || c == 4 || c == 8) begin
                chk("lock_ready", 32'(req_ready), 32'h2);
                push(1);
            end else if (c == 12) begin
                chk("unlock_ready", 32'(req_ready), 32'h4);
                push(2);
            end else begin
                chk("lock_idle", 32'(req_ready), 32'h0);
            end
            if (c == 4) chk("lock_busy", 32'(busy), 32'h1);
            next();
        end
        req_valid = '0;
        repeat (4) next();

        // Back-pressure holds off the accept until out_ready rises
        do_reset();
        req_valid = 4'b0001;
        req_last  = 4'b1111;
        out_ready = 1'b0;
        for (int c = 0; c <= 7; c++) begin
            if (c == 7) out_ready = 1'b1;
            @(negedge clk);
            if (c < 7) begin
                chk("bp_blocked", 32'(req_ready), 32'h0);
            end else begin
                chk("bp_ready", 32'(req_ready), 32'h1);
                push(0);
            end
            next();
        end
        req_valid = '0;
        repeat (4) next();

        // Reset mid-spacing with lane 3 locked
        do_reset();
        req_valid = 4'b1000;
        req_last  = 4'b0000;
        @(negedge clk);
        chk("rl_ready3", 32'(req_ready), 32'h8);
        push(3);
        next();
        req_valid = '0;
        @(negedge clk);
        chk("rl_busy1", 32'(busy), 32'h1);
        next();
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        @(negedge clk);
        chk("rl_ready_rst", 32'(req_ready), 32'h0);
        next();
        rst = 1'b0;
        @(negedge clk);
        chk("rl_busy_after", 32'(busy), 32'h0);
        chk("rl_vq_after", 32'(valid_quad), 32'h0);
        chk("rl_ready0", 32'(req_ready), 32'h1);
        push(0);
        next();
        req_valid = '0;
        repeat (4) next();

`ifdef QUAD_SCHED_STATS_EN
        // Ten back-to-back quads on lane 0, then clear the counters
        do_reset();
        req_valid = 4'b0001;
        req_last  = 4'b1111;
        for (int c = 0; c <= 36; c++) begin
            @(negedge clk);
            if (c % 4 == 0) begin
                chk("st_ready", 32'(req_ready), 32'h1);
                push(0);
            end
            next();
        end
        req_valid = '0;
        @(negedge clk);
        chk("stat_quads", stat_quads, 32'd10);
        chk("stat_stall", stat_stall, 32'd27);
        next();
        stat_clr = 1'b1;
        next();
        stat_clr = 1'b0;
        @(negedge clk);
        chk("stat_quads_clr", stat_quads, 32'd0);
        chk("stat_stall_clr", stat_stall, 32'd0);
        next();
`endif

        repeat (6) next();
        chk("sb_drained", 32'(q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/quad_scheduler.md
Name: quad_scheduler

Overview:
- Arbitrates shaded pixel quads from NUM_REQ shader lanes onto the single quad-to-pixel serializer that feeds the scan-out path.
- Enforces the serializer's 4-cycle-per-quad cadence: a quad is issued, then 3 spacing cycles follow before the next issue.
- Uses round-robin fairness, optionally locked per primitive, and honours a downstream back-pressure signal.

Parameters:
- NUM_REQ, 4, number of requesting shader lanes (2..8).
- IDX_W, $clog2(NUM_REQ), width of grant index.
- SPACING, 4, minimum cycles between valid_quad pulses (serializer quad length).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-lane quad available.
- req_ready  out  NUM_REQ  per-lane accept; one-hot or zero; combinational.
- req_last  in  NUM_REQ  quad is the last of its primitive.
- req_r  in  NUM_REQ*32  packed red quads; lane i at [i*32+:32]; pixel 0 in bits 31:24.
- req_g  in  NUM_REQ*32  packed green quads, same layout.
- req_b  in  NUM_REQ*32  packed blue quads, same layout.
- out_ready  in  1  downstream can absorb 4 more pixels.
- valid_quad  out  1  one-cycle issue strobe to serializer.
- R_quad  out  32  issued red quad.
- G_quad  out  32  issued green quad.
- B_quad  out  32  issued blue quad.
- grant_id  out  IDX_W  lane that sourced the current/last quad.
- busy  out  1  spacing counter nonzero or lock held.

Behaviour:
- Reset values: valid_quad=0, R_quad/G_quad/B_quad=0, grant_id=0, busy=0. Spacing counter=0, lock clear, RR pointer=0 (lane 0 highest priority).
- slot_free = (space_cnt==0) && out_ready && !rst.
- Eligible set:
  - If lock is held: only the locked lane.
  - Otherwise: all lanes with req_valid.
- Grant: round-robin over the eligible set, starting at the lane after the last-granted lane.
- req_ready[g]=1 only when slot_free and lane g is granted. Accept = req_valid[g] && req_ready[g].
- On accept at edge t:
  - At t+1: valid_quad=1 for exactly one cycle; R/G/B_quad = lane g data captured at t; grant_id=g; space_cnt=SPACING-1.
  - RR pointer advances past g.
- space_cnt decrements by 1 per cycle to 0 and saturates there. Earliest next accept is t+SPACING; back-to-back issues give valid_quad every SPACING cycles.
- R/G/B_quad hold their last value when valid_quad=0.
- Lock (LOCK_PRIM, always on):
  - Accepting a quad with req_last=0 sets lock to g.
  - Accepting with req_last=1 clears lock.
  - While locked, other lanes are starved even if the locked lane's req_valid drops.
- out_ready=0 blocks new accepts only. A quad already issued is not retracted, and space_cnt keeps counting.
- No request valid: no grant, req_ready=0, RR pointer unchanged.
- rst asserted mid-spacing or mid-lock: all state returns to reset values at that edge. A quad accepted in the rst cycle is dropped; req_ready is forced 0 while rst=1.
- busy = (space_cnt!=0) || lock_held.

Optional Feature:
- Macro: QUAD_SCHED_STATS_EN.
- With it defined, add the following outputs:
  - stat_quads (32 bit): counts accepts.
  - stat_stall (32 bit): counts cycles where any req_valid=1 but no accept occurred.
  - stat_clr (input, 1): synchronous clear of both counters.
  - Counters wrap at 2^32 and reset to 0 on rst.
- Without it: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then lane 0 valid with R=0xAABBCCDD, last=1, out_ready=1 -> req_ready=0001 at cycle 0; valid_quad=1 at cycle 1 with R_quad=0xAABBCCDD, grant_id=0; busy=1 for cycles 1..3.
- Lanes 0..3 all valid, last=1 continuously -> grants 0,1,2,3,0 at cycles 0,4,8,12,16; valid_quad high exactly at 1,5,9,13,17.
- Lane 1 sends last=0,0,1 while lane 2 is valid throughout -> grants 1,1,1 (cycles 0,4,8), then 2 at cycle 12.
- Lane 0 valid, out_ready=0 for cycles 0..6 then 1 -> no req_ready before cycle 7; accept at 7, valid_quad at 8.
- Accept at cycle 0, rst=1 at cycle 2 with lane 3 locked -> busy=0 and valid_quad=0 from cycle 3; next grant after reset starts from lane 0.
- (QUAD_SCHED_STATS_EN) 10 back-to-back quads on one lane -> stat_quads=10, stat_stall=27; pulse stat_clr -> both read 0 next cycle.
